ex_stage_muldiv: RTL and testbench

- Parametrised next-generation execute stage for the pipelined MIPS core.
- Selects ALU operands exactly as the current EX stage does: shift amount vs. Rs/PC+4, immediate vs. Rt/zero.
- Adds an iterative multiply/divide unit with architectural HI/LO registers, a registered EX/MEM output with valid/ready handshake, and stall generation.
- Sits between the ID/EX pipeline register and the MEM stage.

---
 rtl/ex_stage_pkg.sv | 32 +++
 rtl/ex_stage_muldiv_if.sv | 43 ++++
 rtl/iterative_muldiv.sv | 140 ++++++++++++++
 rtl/ex_stage_muldiv.sv | 147 ++++++++++++++
 tb/tb_ex_stage_muldiv.sv | 330 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ex_stage_pkg.sv
// Shared encodings for the execute stage with iterative multiply/divide.
// Imported by the EX datapath, the mul/div unit and benches.
package ex_stage_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;

  typedef enum logic {
    MD_IDLE,
    MD_RUN
  } md_state_e;

endpackage

// File: rtl/ex_stage_muldiv_if.sv
// ID/EX -> EX -> MEM signal bundle for the execute stage.
// master drives instructions and accepts beats; slave is the stage.
interface ex_stage_muldiv_if #(
  parameter int WIDTH         = 32,
  parameter int REG_ADDR_BITS = 5
);
  logic                     inValid;
  logic                     inReady;
  logic [WIDTH-1:0]         shiftAmount;
  logic [WIDTH-1:0]         immediate;
  logic [WIDTH-1:0]         registerRsOrPc_4;
  logic [WIDTH-1:0]         registerRtOrZero;
  logic                     useShiftAmount;
  logic                     useImmediate;
  logic [3:0]               aluOperation;
  logic [3:0]               mdOperation;
  logic [REG_ADDR_BITS-1:0] destIn;
  logic                     outValid;
  logic                     outReady;
  logic [WIDTH-1:0]         result;
  logic [REG_ADDR_BITS-1:0] destOut;
  logic                     mdBusy;

  modport master (
    output inValid, shiftAmount, immediate,
    output registerRsOrPc_4, registerRtOrZero,
    output useShiftAmount, useImmediate,
    output aluOperation, mdOperation, destIn,
    output outReady,
    input  inReady, outValid, result,
    input  destOut, mdBusy
  );

  modport slave (
    input  inValid, shiftAmount, immediate,
    input  registerRsOrPc_4, registerRtOrZero,
    input  useShiftAmount, useImmediate,
    input  aluOperation, mdOperation, destIn,
    input  outReady,
    output inReady, outValid, result,
    output destOut, mdBusy
  );
endinterface

// File: rtl/iterative_muldiv.sv
// Iterative unsigned-core multiply/divide resolving STEP_BITS per cycle.
// Signs are stripped on start and restored combinationally at the end.
module iterative_muldiv
  import ex_stage_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int STEP_BITS = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic             isSigned,
  input  logic             isDiv,
  output logic             busy,
  output logic             doneStrobe,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int ITERS    = WIDTH / STEP_BITS;
  localparam int CNT_BITS = $clog2(ITERS);
  localparam logic [CNT_BITS-1:0] LAST =
    CNT_BITS'(ITERS - 1);

  md_state_e state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, acc_nx, prod;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic div_q, div_d;
  logic negq_q, negq_d;
  logic negr_q, negr_d;
  logic [WIDTH-1:0] mag_a, mag_b, rem, quo;
  logic [WIDTH+STEP_BITS-1:0] partial, sum;
  logic [WIDTH:0] trial;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MD_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MD_IDLE: if (start) state_d = MD_RUN;
      MD_RUN:  if (cnt_q == '0) state_d = MD_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q == MD_RUN);
    doneStrobe = busy && (cnt_q == '0);
  end

  // acc holds {partial hi, multiplier} or {remainder, quotient}
  always_comb begin
    partial = {{STEP_BITS{1'b0}}, opnd_q}
            * {{WIDTH{1'b0}}, acc_q[STEP_BITS-1:0]};
    sum = {{STEP_BITS{1'b0}}, acc_q[2*WIDTH-1:WIDTH]}
        + partial;
    rem   = acc_q[2*WIDTH-1:WIDTH];
    quo   = acc_q[WIDTH-1:0];
    trial = '0;
    for (int i = 0; i < STEP_BITS; i++) begin
      trial = {rem, quo[WIDTH-1]} - {1'b0, opnd_q};
      if (trial[WIDTH]) begin
        rem = {rem[WIDTH-2:0], quo[WIDTH-1]};
      end else begin
        rem = trial[WIDTH-1:0];
      end
      quo = {quo[WIDTH-2:0], !trial[WIDTH]};
    end
    if (div_q) begin
      acc_nx = {rem, quo};
    end else begin
      acc_nx = {sum, acc_q[WIDTH-1:STEP_BITS]};
    end
  end

  always_comb begin
    prod = negq_q ? -acc_nx : acc_nx;
    if (div_q) begin
      hi = negr_q ? -acc_nx[2*WIDTH-1:WIDTH]
                  : acc_nx[2*WIDTH-1:WIDTH];
      lo = negq_q ? -acc_nx[WIDTH-1:0]
                  : acc_nx[WIDTH-1:0];
    end else begin
      hi = prod[2*WIDTH-1:WIDTH];
      lo = prod[WIDTH-1:0];
    end
  end

  always_comb begin
    mag_a  = (isSigned && opA[WIDTH-1]) ? -opA : opA;
    mag_b  = (isSigned && opB[WIDTH-1]) ? -opB : opB;
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    opnd_d = opnd_q;
    div_d  = div_q;
    negq_d = negq_q;
    negr_d = negr_q;
    if (start && !busy) begin
      cnt_d  = LAST;
      acc_d  = {{WIDTH{1'b0}}, mag_a};
      opnd_d = mag_b;
      div_d  = isDiv;
      // x/0 keeps quotient all ones regardless of signs
      negq_d = isSigned
            && (opA[WIDTH-1] ^ opB[WIDTH-1])
            && !(isDiv && opB == '0);
      negr_d = isSigned && opA[WIDTH-1];
    end else if (busy) begin
      acc_d = acc_nx;
      if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      opnd_q <= '0;
      div_q  <= 1'b0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
      div_q  <= div_d;
      negq_q <= negq_d;
      negr_q <= negr_d;
    end
  end

endmodule

// File: rtl/ex_stage_muldiv.sv
// Execute stage: operand muxing, ALU, HI/LO, iterative mul/div and
// a registered valid/ready output towards MEM.
module ex_stage_muldiv
  import ex_stage_pkg::*;
#(
  parameter int WIDTH         = 32,
  parameter int STEP_BITS     = 1,
  parameter int REG_ADDR_BITS = 5
) (
  input  logic         clock,
  input  logic         resetN,
  ex_stage_muldiv_if.slave bus
);

  localparam int SH_BITS = $clog2(WIDTH);

  logic [WIDTH-1:0] op_a, op_b, alu_y;
  logic [SH_BITS-1:0] shamt;
  logic accept;
  logic md_start, md_signed, md_div, has_beat;
  logic wr_hi, wr_lo, rd_hi, rd_lo;
  logic md_busy, md_done;
  logic [WIDTH-1:0] md_hi, md_lo;

  logic out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [REG_ADDR_BITS-1:0] dest_q, dest_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

  assign bus.inReady = !md_busy
                    && (!out_valid_q || bus.outReady);
  assign accept   = bus.inValid && bus.inReady;
  assign bus.outValid = out_valid_q;
  assign bus.result   = result_q;
  assign bus.destOut  = dest_q;
  assign bus.mdBusy   = md_busy;

  always_comb begin
    op_a = bus.useShiftAmount ? bus.shiftAmount
                              : bus.registerRsOrPc_4;
    op_b = bus.useImmediate ? bus.immediate
                            : bus.registerRtOrZero;
    shamt = op_a[SH_BITS-1:0];
    unique case (bus.aluOperation)
      ALU_ADD:  alu_y = op_a + op_b;
      ALU_SUB:  alu_y = op_a - op_b;
      ALU_AND:  alu_y = op_a & op_b;
      ALU_OR:   alu_y = op_a | op_b;
      ALU_XOR:  alu_y = op_a ^ op_b;
      ALU_NOR:  alu_y = ~(op_a | op_b);
      ALU_SLT:  alu_y = {{(WIDTH-1){1'b0}},
                         $signed(op_a) < $signed(op_b)};
      ALU_SLTU: alu_y = {{(WIDTH-1){1'b0}}, op_a < op_b};
      ALU_SLL:  alu_y = op_b << shamt;
      ALU_SRL:  alu_y = op_b >> shamt;
      ALU_SRA:  alu_y = $signed(op_b) >>> shamt;
      default:  alu_y = '0;
    endcase
  end

  always_comb begin
    md_start  = 1'b0;
    md_signed = 1'b0;
    md_div    = 1'b0;
    has_beat  = 1'b1;
    wr_hi     = 1'b0;
    wr_lo     = 1'b0;
    rd_hi     = 1'b0;
    rd_lo     = 1'b0;
    unique case (bus.mdOperation)
      MD_MULT:  begin md_start = 1'b1; md_signed = 1'b1;
                      has_beat = 1'b0; end
      MD_MULTU: begin md_start = 1'b1; has_beat = 1'b0; end
      MD_DIV:   begin md_start = 1'b1; md_signed = 1'b1;
                      md_div = 1'b1; has_beat = 1'b0; end
      MD_DIVU:  begin md_start = 1'b1; md_div = 1'b1;
                      has_beat = 1'b0; end
      MD_MFHI:  rd_hi = 1'b1;
      MD_MFLO:  rd_lo = 1'b1;
      MD_MTHI:  begin wr_hi = 1'b1; has_beat = 1'b0; end
      MD_MTLO:  begin wr_lo = 1'b1; has_beat = 1'b0; end
      default:  has_beat = 1'b1;
    endcase
  end

  iterative_muldiv #(
    .WIDTH     (WIDTH),
    .STEP_BITS (STEP_BITS)
  ) u_muldiv (
    .clk        (clock),
    .rst_n      (resetN),
    .start      (accept && md_start),
    .opA        (bus.registerRsOrPc_4),
    .opB        (bus.registerRtOrZero),
    .isSigned   (md_signed),
    .isDiv      (md_div),
    .busy       (md_busy),
    .doneStrobe (md_done),
    .hi         (md_hi),
    .lo         (md_lo)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    result_d    = result_q;
    dest_d      = dest_q;
    if (accept && has_beat) begin
      out_valid_d = 1'b1;
      dest_d      = bus.destIn;
      if (rd_hi)      result_d = hi_q;
      else if (rd_lo) result_d = lo_q;
      else            result_d = alu_y;
    end else if (bus.outReady) begin
      out_valid_d = 1'b0;
    end
  end

  // accept is blocked while busy, so done and MTHI/MTLO never collide
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (md_done) begin
      hi_d = md_hi;
      lo_d = md_lo;
    end else if (accept) begin
      if (wr_hi) hi_d = bus.registerRsOrPc_4;
      if (wr_lo) lo_d = bus.registerRsOrPc_4;
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      dest_q      <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      dest_q      <= dest_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
    end
  end

endmodule

// File: tb/tb_ex_stage_muldiv.sv
// Bench for ex_stage_muldiv: transaction model compared every cycle,
// plus literal checks on selected results and a STEP_BITS=4 build.
module tb_ex_stage_muldiv;
  import ex_stage_pkg::*;

  logic clk = 1'b0;
  logic resetN = 1'b1;
  always #5 clk = ~clk;

  ex_stage_muldiv_if #(.WIDTH(32), .REG_ADDR_BITS(5)) bus ();
  ex_stage_muldiv_if #(.WIDTH(32), .REG_ADDR_BITS(5)) bus4 ();

  ex_stage_muldiv #(
    .WIDTH(32), .STEP_BITS(1), .REG_ADDR_BITS(5)
  ) dut (
    .clock(clk), .resetN(resetN), .bus(bus.slave)
  );

  ex_stage_muldiv #(
    .WIDTH(32), .STEP_BITS(4), .REG_ADDR_BITS(5)
  ) dut4 (
    .clock(clk), .resetN(resetN), .bus(bus4.slave)
  );

  int checks = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  int          m_busy = 0;
  logic [31:0] m_hi = 0, m_lo = 0, m_res = 0;
  logic [63:0] m_pend = 0;
  logic [4:0]  m_dest = 0;
  logic        m_ov = 0;
  logic        m_rdy, m_acc;

  function automatic logic [31:0] alu_ref(
    input logic [3:0] op, input logic [31:0] a, b);
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_NOR:  return ~(a | b);
      ALU_SLT:  return {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU: return {31'b0, a < b};
      ALU_SLL:  return b << a[4:0];
      ALU_SRL:  return b >> a[4:0];
      ALU_SRA:  return $signed(b) >>> a[4:0];
      default:  return 32'h0;
    endcase
  endfunction

  // returns {HI, LO}
  function automatic logic [63:0] md_ref(
    input logic [3:0] op, input logic [31:0] a, b);
    longint sp;
    logic [31:0] q, r;
    if (op == MD_MULT) begin
      sp = longint'($signed(a)) * longint'($signed(b));
      return sp;
    end
    if (op == MD_MULTU) return {32'b0, a} * {32'b0, b};
    if (b == 0) return {a, 32'hFFFF_FFFF};
    if (op == MD_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return {32'h0, a};
    if (op == MD_DIV) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  function automatic bit is_md(input logic [3:0] op);
    return op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
  endfunction

  function automatic bit gives_beat(input logic [3:0] op);
    return !(is_md(op) || op == MD_MTHI || op == MD_MTLO);
  endfunction

  assign m_rdy = (m_busy == 0) && (!m_ov || bus.outReady);
  assign m_acc = bus.inValid && m_rdy;

  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      m_busy <= 0;
      m_hi   <= 0;
      m_lo   <= 0;
      m_ov   <= 0;
      m_res  <= 0;
      m_dest <= 0;
    end else begin
      if (m_busy > 0) m_busy <= m_busy - 1;
      if (m_busy == 1) {m_hi, m_lo} <= m_pend;
      if (m_acc && gives_beat(bus.mdOperation)) begin
        m_ov   <= 1'b1;
        m_dest <= bus.destIn;
        if (bus.mdOperation == MD_MFHI) m_res <= m_hi;
        else if (bus.mdOperation == MD_MFLO) m_res <= m_lo;
        else m_res <= alu_ref(bus.aluOperation,
          bus.useShiftAmount ? bus.shiftAmount : bus.registerRsOrPc_4,
          bus.useImmediate ? bus.immediate : bus.registerRtOrZero);
      end else if (bus.outReady) begin
        m_ov <= 1'b0;
      end
      if (m_acc && is_md(bus.mdOperation)) begin
        m_pend <= md_ref(bus.mdOperation,
                         bus.registerRsOrPc_4, bus.registerRtOrZero);
        m_busy <= 32;
      end
      if (m_acc && bus.mdOperation == MD_MTHI) m_hi <= bus.registerRsOrPc_4;
      if (m_acc && bus.mdOperation == MD_MTLO) m_lo <= bus.registerRsOrPc_4;
    end
  end

  always @(negedge clk) begin
    checks++;
    if (bus.mdBusy !== (m_busy > 0) || bus.inReady !== m_rdy
        || bus.outValid !== m_ov || bus.result !== m_res
        || bus.destOut !== m_dest) begin
      failures++;
      $display("FAIL cycle_compare t=%0t got busy=%b rdy=%b ov=%b res=%h dst=%0d exp busy=%b rdy=%b ov=%b res=%h dst=%0d",
               $time, bus.mdBusy, bus.inReady, bus.outValid, bus.result,
               bus.destOut, m_busy > 0, m_rdy, m_ov, m_res, m_dest);
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name,
                       input logic [31:0] got, exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic issue(input logic [3:0] md, alu,
                       input logic [31:0] rs, rt, sh, imm,
                       input logic us, ui, input logic [4:0] dst,
                       output int stalls);
    logic r;
    bit done;
    bus.mdOperation      = md;
    bus.aluOperation     = alu;
    bus.registerRsOrPc_4 = rs;
    bus.registerRtOrZero = rt;
    bus.shiftAmount      = sh;
    bus.immediate        = imm;
    bus.useShiftAmount   = us;
    bus.useImmediate     = ui;
    bus.destIn           = dst;
    bus.inValid          = 1'b1;
    stalls = 0;
    done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      r = bus.inReady;
      @(posedge clk);
      #1;
      if (r) done = 1;
      else stalls++;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL issue_timeout md=%0d", md);
    end
    bus.inValid = 1'b0;
  endtask

  task automatic md(input logic [3:0] op, input logic [31:0] rs, rt);
    int st;
    issue(op, ALU_ADD, rs, rt, 0, 0, 1'b0, 1'b0, 5'd0, st);
  endtask

  task automatic rd(input logic [3:0] op, input string name,
                    input logic [31:0] exp);
    int st;
    issue(op, ALU_ADD, 0, 0, 0, 0, 1'b0, 1'b0, 5'd9, st);
    @(negedge clk);
    check(name, bus.result, exp);
  endtask

  task automatic issue4(input logic [3:0] op, input logic [31:0] rs, rt);
    logic r;
    bit done;
    bus4.mdOperation      = op;
    bus4.registerRsOrPc_4 = rs;
    bus4.registerRtOrZero = rt;
    bus4.inValid          = 1'b1;
    done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      r = bus4.inReady;
      @(posedge clk);
      #1;
      if (r) done = 1;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL issue4_timeout md=%0d", op);
    end
    bus4.inValid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int st, tot, n;
    bus.inValid = 0; bus.outReady = 1;
    bus.shiftAmount = 0; bus.immediate = 0;
    bus.registerRsOrPc_4 = 0; bus.registerRtOrZero = 0;
    bus.useShiftAmount = 0; bus.useImmediate = 0;
    bus.aluOperation = 0; bus.mdOperation = 0; bus.destIn = 0;
    bus4.inValid = 0; bus4.outReady = 1;
    bus4.shiftAmount = 0; bus4.immediate = 0;
    bus4.registerRsOrPc_4 = 0; bus4.registerRtOrZero = 0;
    bus4.useShiftAmount = 0; bus4.useImmediate = 0;
    bus4.aluOperation = 0; bus4.mdOperation = 0; bus4.destIn = 0;

    #1 resetN = 0;
    #20;
    check("rst_outValid", {31'b0, bus.outValid}, 0);
    check("rst_result", bus.result, 0);
    check("rst_destOut", {27'b0, bus.destOut}, 0);
    check("rst_mdBusy", {31'b0, bus.mdBusy}, 0);
    @(posedge clk); #1 resetN = 1;

    issue(MD_NONE, ALU_ADD, 5, 99, 0, 3, 1'b0, 1'b1, 5'd3, st);
    @(negedge clk);
    check("add_valid", {31'b0, bus.outValid}, 1);
    check("add_result", bus.result, 8);
    check("add_dest", {27'b0, bus.destOut}, 3);

    tot = 0;
    issue(MD_NONE, ALU_SUB, 20, 7, 0, 0, 1'b0, 1'b0, 5'd4, st); tot += st;
    issue(MD_NONE, ALU_SLL, 0, 1, 4, 0, 1'b1, 1'b0, 5'd5, st); tot += st;
    issue(MD_NONE, ALU_OR, 32'hF0, 0, 0, 32'h0F, 1'b0, 1'b1, 5'd6, st);
    tot += st;
    issue(4'd12, ALU_ADD, 1, 1, 0, 0, 1'b0, 1'b0, 5'd7, st); tot += st;
    issue(MD_NONE, ALU_SRA, 0, 32'h8000_0000, 4, 0, 1'b1, 1'b0, 5'd8, st);
    tot += st;
    @(negedge clk);
    check("sra_result", bus.result, 32'hF800_0000);
    check("b2b_stalls", tot, 0);

    md(MD_MULT, 32'hFFFF_FFFA, 7);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!bus.mdBusy) break;
      n++;
    end
    check("mult_busy_cycles", n, 32);
    rd(MD_MFLO, "mult_lo", 32'hFFFF_FFD6);
    rd(MD_MFHI, "mult_hi", 32'hFFFF_FFFF);

    md(MD_DIV, 7, 32'hFFFF_FFFE);
    rd(MD_MFLO, "div_lo", 32'hFFFF_FFFD);
    rd(MD_MFHI, "div_hi", 1);
    md(MD_DIVU, 7, 0);
    rd(MD_MFLO, "divu0_lo", 32'hFFFF_FFFF);
    rd(MD_MFHI, "divu0_hi", 7);
    md(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    rd(MD_MFLO, "ovf_lo", 32'h8000_0000);
    rd(MD_MFHI, "ovf_hi", 0);
    md(MD_DIV, 32'hFFFF_FFFB, 0);
    rd(MD_MFLO, "div0_lo", 32'hFFFF_FFFF);
    rd(MD_MFHI, "div0_hi", 32'hFFFF_FFFB);
    md(MD_MTHI, 32'h1234_5678, 0);
    md(MD_MTLO, 32'hCAFE_F00D, 0);
    rd(MD_MFHI, "mthi", 32'h1234_5678);
    rd(MD_MFLO, "mtlo", 32'hCAFE_F00D);

    @(posedge clk); #1;
    bus.outReady = 0;
    issue(MD_NONE, ALU_ADD, 1, 0, 0, 2, 1'b0, 1'b1, 5'd7, st);
    bus.mdOperation = MD_NONE; bus.aluOperation = ALU_SUB;
    bus.registerRsOrPc_4 = 9; bus.registerRtOrZero = 4;
    bus.useShiftAmount = 0; bus.useImmediate = 0;
    bus.destIn = 5'd8; bus.inValid = 1;
    repeat (4) begin
      @(negedge clk);
      check("bp_ready", {31'b0, bus.inReady}, 0);
      check("bp_result", bus.result, 3);
      check("bp_dest", {27'b0, bus.destOut}, 7);
    end
    bus.outReady = 1;
    #1 check("bp_release_ready", {31'b0, bus.inReady}, 1);
    @(posedge clk); #1 bus.inValid = 0;
    @(negedge clk);
    check("bp_next_result", bus.result, 5);
    check("bp_next_dest", {27'b0, bus.destOut}, 8);

    md(MD_MTHI, 32'hAAAA_5555, 0);
    md(MD_DIV, 100, 7);
    repeat (10) @(negedge clk);
    #2 resetN = 0;
    #1;
    check("rstmid_busy", {31'b0, bus.mdBusy}, 0);
    check("rstmid_valid", {31'b0, bus.outValid}, 0);
    @(posedge clk); #1 resetN = 1;
    rd(MD_MFHI, "rstmid_hi", 0);
    rd(MD_MFLO, "rstmid_lo", 0);

    issue4(MD_MULTU, 32'hFFFF_FFFF, 2);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!bus4.mdBusy) break;
      n++;
    end
    check("s4_busy_cycles", n, 8);
    issue4(MD_MFHI, 0, 0);
    @(negedge clk);
    check("s4_hi", bus4.result, 1);
    issue4(MD_MFLO, 0, 0);
    @(negedge clk);
    check("s4_lo", bus4.result, 32'hFFFF_FFFE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
